hazard_stall_ctrl: RTL and testbench

- Consumes the single-bit combined hazard request from the six-input OR reduction in the ID stage, plus multiply/divide launch and branch-resolve events from EX.
- Drives the pipeline write enables: PC, IF/ID, ID/EX bubble, and the IF/ID flush.
- Sequences multi-cycle multiply/divide holds with a down-counter.
- Flags runaway stalls with a sticky watchdog bit.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_stall_ctrl_if.sv | 45 ++++
 rtl/stall_down_counter.sv | 36 +++
 rtl/hazard_stall_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/stall controller.
// Optional build macro used by the controller: STALL_PERF_CNT_EN.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hazard_state_e;

    localparam int DEF_CNT_W     = 4;
    localparam int DEF_MAX_STALL = 15;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [3:0] alu_op;
    } idex_ctrl_t;

    // All-zero control word: no register, memory or branch side effects.
    localparam idex_ctrl_t NOP_CTRL = '0;

    function automatic idex_ctrl_t bubble_mux(input idex_ctrl_t ctrl, input logic bubble);
        return bubble ? NOP_CTRL : ctrl;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// stall_cycles exists only when STALL_PERF_CNT_EN is defined.
interface hazard_stall_ctrl_if
    import hazard_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    // Event inputs are sampled on every rising clk edge; there is no
    // back-pressure: md_start and branch_flush are one-cycle pulses and
    // the controller answers combinationally in the same cycle.
    logic             stall_any;
    logic             md_start;
    logic [CNT_W-1:0] md_latency;
    logic             branch_flush;

    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             stall_active;
    logic             stall_timeout;
    hazard_state_e    state_dbg;
`ifdef STALL_PERF_CNT_EN
    logic [31:0]      stall_cycles;
`endif

    modport master (
        output stall_any, md_start, md_latency, branch_flush,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, stall_active,
        input  stall_timeout, state_dbg
`ifdef STALL_PERF_CNT_EN
      , input  stall_cycles
`endif
    );

    modport slave (
        input  stall_any, md_start, md_latency, branch_flush,
        output pc_we, ifid_we, ifid_flush, idex_bubble, stall_active,
        output stall_timeout, state_dbg
`ifdef STALL_PERF_CNT_EN
      , output stall_cycles
`endif
    );

endinterface

// File: rtl/stall_down_counter.sv
// Loadable down-counter for mul/div holds; last flags count==1.
module stall_down_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == CNT_W'(1));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller with mul/div hold sequencing and a
// sticky stall watchdog. Define STALL_PERF_CNT_EN for the stall cycle counter.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MAX_STALL = DEF_MAX_STALL
) (
    input  logic                     clk,
    input  logic                     rst_n,
    hazard_stall_ctrl_if.slave       bus
);

    localparam int                RL_W   = $clog2(MAX_STALL + 2);
    localparam logic [RL_W-1:0]   RL_SAT = RL_W'(MAX_STALL + 1);

    hazard_state_e    state_d, state_q;
    logic             md_load;
    logic             md_dec;
    logic             md_last;
    logic [CNT_W-1:0] md_count;

    logic [RL_W-1:0]  run_len_d, run_len_q;
    logic             stall_timeout_d, stall_timeout_q;
    logic             held;

    stall_down_counter #(.CNT_W(CNT_W)) u_md_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (md_load),
        .load_val (bus.md_latency),
        .dec      (md_dec),
        .count    (md_count),
        .last     (md_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A zero-latency mul/div launch needs no hold and never leaves RUN.
    always_comb begin
        state_d = state_q;
        md_load = 1'b0;
        md_dec  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.md_start && (bus.md_latency != '0)) begin
                    md_load = 1'b1;
                    state_d = MD_WAIT;
                end
            end
            MD_WAIT: begin
                md_dec = 1'b1;
                if (md_last) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Branch flush in RUN wins over stall_any so the wrong-path ID slot is
    // overwritten; in MD_WAIT the hold on PC and IF/ID is kept.
    always_comb begin
        held = (state_q == MD_WAIT) || (bus.stall_any && !bus.branch_flush);
        bus.pc_we        = !held;
        bus.ifid_we      = !held;
        bus.idex_bubble  = held || bus.branch_flush;
        bus.ifid_flush   = bus.branch_flush;
        bus.stall_active = held;
        bus.state_dbg    = state_q;
    end

    always_comb begin
        run_len_d = run_len_q;
        if (!held) begin
            run_len_d = '0;
        end else if (run_len_q != RL_SAT) begin
            run_len_d = run_len_q + 1'b1;
        end
        stall_timeout_d = stall_timeout_q || (run_len_d == RL_SAT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_len_q       <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            run_len_q       <= run_len_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    assign bus.stall_timeout = stall_timeout_q;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles_d, stall_cycles_q;

    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, held};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
`else
`endif

`ifndef SYNTHESIS
    md_start_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        !((state_q == MD_WAIT) && bus.md_start))
        else $error("md_start asserted while a mul/div hold is in progress");
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with an expected-vector queue.
// Build with STALL_PERF_CNT_EN to also cover stall_cycles.
module tb_hazard_stall_ctrl;
  import hazard_pkg::*;

  // {pc_we, ifid_we, ifid_flush, idex_bubble, stall_active, stall_timeout}
  localparam logic [5:0] RUN_V    = 6'b110000;
  localparam logic [5:0] HOLD_V   = 6'b000110;
  localparam logic [5:0] FLRUN_V  = 6'b111100;
  localparam logic [5:0] FLMD_V   = 6'b001110;
  localparam logic [5:0] RUN_TO_V = 6'b110001;
  localparam logic [5:0] HOLD_TO_V= 6'b000111;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [5:0] exp_q[$];

  hazard_stall_ctrl_if #(.CNT_W(4)) bus ();

  hazard_stall_ctrl #(.CNT_W(4), .MAX_STALL(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] out_vec();
    return {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_bubble,
            bus.stall_active, bus.stall_timeout};
  endfunction

  task automatic compare(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic ms, input logic [3:0] lat, input logic bf);
    bus.stall_any    = s;
    bus.md_start     = ms;
    bus.md_latency   = lat;
    bus.branch_flush = bf;
  endtask

  // Drive one cycle of inputs, expect a vector, check at the falling edge.
  task automatic step(input string tag, input logic s, input logic ms,
                      input logic [3:0] lat, input logic bf, input logic [5:0] exp);
    logic [5:0] e;
    drive(s, ms, lat, bf);
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    compare(tag, 32'(out_vec()), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic [5:0] exp);
    step(tag, 1'b0, 1'b0, 4'd0, 1'b0, exp);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    #12;
    compare("reset_outputs", 32'(out_vec()), 32'(RUN_V));
    compare("reset_state", 32'(bus.state_dbg), 32'(RUN));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    idle("run_idle", RUN_V);

    // Single-cycle load-use stall
    step("stall_1", 1'b1, 1'b0, 4'd0, 1'b0, HOLD_V);
    idle("stall_release", RUN_V);

    // mul/div latency 3: unheld launch then exactly 3 held cycles
    step("md3_launch", 1'b0, 1'b1, 4'd3, 1'b0, RUN_V);
    for (int i = 0; i < 3; i++) idle("md3_hold", HOLD_V);
    idle("md3_done", RUN_V);

    step("md0_launch", 1'b0, 1'b1, 4'd0, 1'b0, RUN_V);
    idle("md0_nohold", RUN_V);

    // Flush beats stall in RUN
    step("flush_stall_run", 1'b1, 1'b0, 4'd0, 1'b1, FLRUN_V);
    idle("flush_after", RUN_V);

    // Flush inside a mul/div hold keeps the hold
    step("md2_launch", 1'b0, 1'b1, 4'd2, 1'b0, RUN_V);
    step("flush_in_wait", 1'b0, 1'b0, 4'd0, 1'b1, FLMD_V);
    idle("md2_hold2", HOLD_V);
    idle("md2_done", RUN_V);

    // Flush and launch together: both take effect
    step("flush_md_launch", 1'b0, 1'b1, 4'd2, 1'b1, FLRUN_V);
    idle("flmd_hold1", HOLD_V);
    idle("flmd_hold2", HOLD_V);
    idle("flmd_done", RUN_V);

    // Longest hold: latency 15 gives 15 held cycles
    step("md15_launch", 1'b0, 1'b1, 4'd15, 1'b0, RUN_V);
    for (int i = 0; i < 15; i++) idle("md15_hold", HOLD_V);
    idle("md15_done", RUN_V);

    // Watchdog: 15 held cycles stays clear
    for (int i = 0; i < 15; i++) step("wd15_hold", 1'b1, 1'b0, 4'd0, 1'b0, HOLD_V);
    idle("wd15_clear", RUN_V);

    // 16 held cycles sets the sticky bit after the last one
    for (int i = 0; i < 16; i++) step("wd16_hold", 1'b1, 1'b0, 4'd0, 1'b0, HOLD_V);
    idle("wd16_set", RUN_TO_V);
    idle("wd16_sticky", RUN_TO_V);

    // Reset in the middle of a mul/div hold (counter at 3)
    step("rst_md_launch", 1'b0, 1'b1, 4'd5, 1'b0, RUN_TO_V);
    idle("rst_md_hold5", HOLD_TO_V);
    idle("rst_md_hold4", HOLD_TO_V);
    compare("pre_rst_state", 32'(bus.state_dbg), 32'(MD_WAIT));
    rst_n = 1'b0;
    #1;
    compare("rst_mid_state", 32'(bus.state_dbg), 32'(RUN));
    compare("rst_mid_outputs", 32'(out_vec()), 32'(RUN_V));
    @(posedge clk);
    #1;
    compare("rst_held_outputs", 32'(out_vec()), 32'(RUN_V));
    rst_n = 1'b1;
    idle("post_rst", RUN_V);
    idle("post_rst2", RUN_V);

`ifdef STALL_PERF_CNT_EN
    rst_n = 1'b0;
    #1;
    compare("perf_reset", bus.stall_cycles, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("perf_stall1", 1'b1, 1'b0, 4'd0, 1'b0, HOLD_V);
    step("perf_stall2", 1'b1, 1'b0, 4'd0, 1'b0, HOLD_V);
    step("perf_md4", 1'b0, 1'b1, 4'd4, 1'b0, RUN_V);
    for (int i = 0; i < 4; i++) idle("perf_hold", HOLD_V);
    idle("perf_done", RUN_V);
    compare("perf_count", bus.stall_cycles, 32'd6);
`endif

    compare("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
